// File: rtl/dpcm_enc_multi.sv
// ---------------------------------------------------------------------------
// dpcm_enc_multi
//   Three-channel DC DPCM encoder for the JPEG path. Y, Cr and Cb quantised DC
//   coefficients share one input stream and are tagged by mode. Each channel
//   keeps its own predictor and block counter. The encoder emits the signed DC
//   difference through a single-stage valid/ready output register.
//
//   Optional feature: define DPCM_SAT_EN to clamp the difference to the
//   DATA_W signed range. The result is then sign-extended onto out_data.
//
// Parameters
//   DATA_W    width of the signed DC input
//   BLOCKS_Y  DC samples per frame on Y
//   BLOCKS_C  DC samples per frame on each of Cr and Cb
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous flush of all predictors and counters
//   mode       channel tag: 01 Y, 10 Cr, 11 Cb, 00 illegal
//   in_data    signed DC coefficient
//   in_valid   in_data/mode valid
//   in_ready   block can accept this cycle
//   out_data   signed DPCM difference (DATA_W+1 bits)
//   out_mode   channel tag of out_data
//   out_valid  out_data valid
//   out_ready  downstream accepts this cycle
//   out_last   out_data is the final sample of its channel's frame
//   mode_err   one-cycle pulse after an input with mode 00 is accepted
//   ch_busy    bit i set while channel i (0=Y, 1=Cr, 2=Cb) is mid-frame
// ---------------------------------------------------------------------------
module dpcm_enc_multi #(
   parameter int DATA_W   = 12,
   parameter int BLOCKS_Y = 256,
   parameter int BLOCKS_C = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W:0]   out_data,
   output logic [1:0]        out_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              mode_err,
   output logic [2:0]        ch_busy
);

   localparam int BLOCKS_MAX = (BLOCKS_Y > BLOCKS_C) ? BLOCKS_Y : BLOCKS_C;
   localparam int CNT_W      = $clog2(BLOCKS_MAX + 1);

   typedef enum logic [1:0] {
      MODE_ILL = 2'b00,
      MODE_Y   = 2'b01,
      MODE_CR  = 2'b10,
      MODE_CB  = 2'b11
   } mode_t;

   logic signed [DATA_W-1:0] pred [3];
   logic        [CNT_W-1:0]  cnt  [3];

   logic                     accept;
   logic                     legal;
   logic                     load;
   logic [1:0]               ch;
   logic [CNT_W-1:0]         cnt_inc;
   logic [CNT_W-1:0]         blocks_sel;
   logic                     is_last;
   logic signed [DATA_W:0]   in_ext;
   logic signed [DATA_W:0]   pred_ext;
   logic signed [DATA_W:0]   diff;
   logic signed [DATA_W:0]   diff_q;

`ifdef DPCM_SAT_EN
   localparam logic signed [DATA_W:0] SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W:0] SAT_MIN = {2'b11, {(DATA_W-1){1'b0}}};
`endif

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign load     = accept && legal && !clear;

   // NOTE: every signal driven here gets a default first, so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      legal      = 1'b1;
      ch         = 2'd0;
      blocks_sel = CNT_W'(BLOCKS_C);
      case (mode_t'(mode))
         MODE_Y:  begin ch = 2'd0; blocks_sel = CNT_W'(BLOCKS_Y); end
         MODE_CR: ch = 2'd1;
         MODE_CB: ch = 2'd2;
         default: legal = 1'b0;
      endcase
   end

   assign cnt_inc  = cnt[ch] + CNT_W'(1);
   assign is_last  = (cnt_inc == blocks_sel);

   // Both operands are widened by one bit, so the subtraction is exact.
   assign in_ext   = {in_data[DATA_W-1], in_data};
   assign pred_ext = {pred[ch][DATA_W-1], pred[ch]};
   assign diff     = in_ext - pred_ext;

`ifdef DPCM_SAT_EN
   always_comb begin
      diff_q = diff;
      if (diff > SAT_MAX)      diff_q = SAT_MAX;
      else if (diff < SAT_MIN) diff_q = SAT_MIN;
   end
`else
   assign diff_q = diff;
`endif

   // Per-channel state. IDLE/RUN is derived from the counter, not stored.
   // The last sample of a frame returns the channel to a raw start.
   // NOTE: the predictor array is small and its reset value is part of the
   // behaviour (the first frame starts from raw), so it is reset like any flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            pred[i] <= '0;
            cnt[i]  <= '0;
         end
      end else if (clear) begin
         for (int i = 0; i < 3; i++) begin
            pred[i] <= '0;
            cnt[i]  <= '0;
         end
      end else if (load) begin
         if (is_last) begin
            pred[ch] <= '0;
            cnt[ch]  <= '0;
         end else begin
            pred[ch] <= in_data;
            cnt[ch]  <= cnt_inc;
         end
      end
   end

   // Single-stage output register. A pending output survives clear and is
   // held while downstream stalls. in_ready is low in that case, so load
   // cannot overwrite it.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mode  <= 2'b00;
         out_last  <= 1'b0;
         mode_err  <= 1'b0;
      end else begin
         mode_err <= accept && !legal && !clear;
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= diff_q;
            out_mode  <= mode;
            out_last  <= is_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) ch_busy[i] = (cnt[i] != '0);
   end

endmodule
